// File: rtl/wb_queue.sv
// Writeback queue: merges ALU/load (A) and mult/div (B) results into the single
// register-file write port, draining one entry per cycle with decode forwarding.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [4:0]    a_wn,
    input  logic [31:0]   a_wd,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [4:0]    b_wn,
    input  logic [31:0]   b_wd,
    output logic          RegWrite,
    output logic [4:0]    WN,
    output logic [31:0]   WD,
    input  logic [4:0]    RN1,
    input  logic [4:0]    RN2,
    output logic          fwd1_hit,
    output logic [31:0]   fwd1_data,
    output logic          fwd2_hit,
    output logic [31:0]   fwd2_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [4:0]    wn_mem [DEPTH];
    logic [31:0]   wd_mem [DEPTH];

    logic          a_store;
    logic          b_store;
    logic          pop;
    logic [AW-1:0] a_slot;
    logic [AW-1:0] b_slot;

    // Space is judged on the start-of-cycle count; a same-cycle pop earns no credit.
    assign a_ready = (count_q < DEPTH_C);
    assign a_store = a_valid && a_ready && (a_wn != 5'd0);
    assign b_ready = ((count_q + (AW+1)'(a_store)) < DEPTH_C);
    assign b_store = b_valid && b_ready && (b_wn != 5'd0);
    assign pop     = (count_q != '0);

    // A is older, so it takes the first free slot and B the one after it.
    assign a_slot  = wr_ptr_q;
    assign b_slot  = wr_ptr_q + AW'(a_store);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(a_store) + AW'(b_store);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(a_store) + (AW+1)'(b_store) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (a_store) begin
            wn_mem[a_slot] <= a_wn;
            wd_mem[a_slot] <= a_wd;
        end
        if (b_store) begin
            wn_mem[b_slot] <= b_wn;
            wd_mem[b_slot] <= b_wd;
        end
    end

    assign count    = count_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign RegWrite = pop;
    assign WN       = pop ? wn_mem[rd_ptr_q] : 5'd0;
    assign WD       = pop ? wd_mem[rd_ptr_q] : 32'd0;

    // Entries viewed oldest (index 0) to youngest, so a later match overrides.
    logic          age_occ [DEPTH];
    logic [4:0]    age_wn  [DEPTH];
    logic [31:0]   age_wd  [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [AW-1:0] idx;
            assign idx         = rd_ptr_q + AW'(gi);
            assign age_occ[gi] = ((AW+1)'(gi) < count_q);
            assign age_wn[gi]  = wn_mem[idx];
            assign age_wd[gi]  = wd_mem[idx];
        end
    endgenerate

    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_occ[i] && (RN1 != 5'd0) && (age_wn[i] == RN1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = age_wd[i];
            end
            if (age_occ[i] && (RN2 != 5'd0) && (age_wn[i] == RN2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = age_wd[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: expected writes are queued at issue time and a
// negedge monitor compares every register-file write against them.
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_wn = '0, b_wn = '0, RN1 = '0, RN2 = '0;
    logic [31:0] a_wd = '0, b_wd = '0;
    logic        a_ready, b_ready, RegWrite, fwd1_hit, fwd2_hit, full, empty;
    logic [4:0]  WN;
    logic [31:0] WD, fwd1_data, fwd2_data;
    logic [AW:0] count;

    // Second, 2-deep instance: the only depth where a full queue is reachable
    logic        a2_valid = 1'b0, b2_valid = 1'b0;
    logic [4:0]  a2_wn = '0, b2_wn = '0;
    logic [31:0] a2_wd = '0, b2_wd = '0;
    logic        a2_ready, b2_ready, RegWrite2, f1h2, f2h2, full2, empty2;
    logic [4:0]  WN2;
    logic [31:0] WD2, f1d2, f2d2;
    logic [1:0]  count2;

    wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_wn(a_wn), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wn(b_wn), .b_wd(b_wd),
        .RegWrite(RegWrite), .WN(WN), .WD(WD), .RN1(RN1), .RN2(RN2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count), .full(full), .empty(empty)
    );

    wb_queue #(.DEPTH(2), .AW(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a2_valid), .a_ready(a2_ready), .a_wn(a2_wn), .a_wd(a2_wd),
        .b_valid(b2_valid), .b_ready(b2_ready), .b_wn(b2_wn), .b_wd(b2_wd),
        .RegWrite(RegWrite2), .WN(WN2), .WD(WD2), .RN1(5'd0), .RN2(5'd0),
        .fwd1_hit(f1h2), .fwd1_data(f1d2), .fwd2_hit(f2h2), .fwd2_data(f2d2),
        .count(count2), .full(full2), .empty(empty2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wn;
        logic [31:0] wd;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && RegWrite) begin
            $display("write wn=%0d wd=%h", WN, WD);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got write wn=%0d wd=%h expected none", WN, WD);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_wn", 32'(WN), 32'(mon_e.wn));
                check("wb_wd", WD, mon_e.wd);
            end
        end
    end

    // Called at posedge+1; inputs are held through the next edge, then dropped.
    task automatic drive(input logic av, input logic [4:0] awn, input logic [31:0] awd,
                         input logic bv, input logic [4:0] bwn, input logic [31:0] bwd,
                         input logic exp_ar, input logic exp_br);
        a_valid = av; a_wn = awn; a_wd = awd;
        b_valid = bv; b_wn = bwn; b_wd = bwd;
        if (av && exp_ar && awn != 5'd0) exp_q.push_back(wr_t'{wn: awn, wd: awd});
        if (bv && exp_br && bwn != 5'd0) exp_q.push_back(wr_t'{wn: bwn, wd: bwd});
        $display("issue a=%0b/%0d/%h b=%0b/%0d/%h", av, awn, awd, bv, bwn, bwd);
        #2;
        if (av) check("a_ready", 32'(a_ready), 32'(exp_ar));
        if (bv) check("b_ready", 32'(b_ready), 32'(exp_br));
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic state(input int exp_count, input logic [4:0] exp_wn, input logic [31:0] exp_wd);
        check("count", 32'(count), exp_count);
        check("RegWrite", 32'(RegWrite), 32'(exp_count != 0));
        check("empty", 32'(empty), 32'(exp_count == 0));
        check("full", 32'(full), 32'(exp_count == DEPTH));
        check("WN", 32'(WN), 32'(exp_wn));
        check("WD", WD, exp_wd);
    endtask

    initial begin
        #2;
        state(0, 5'd0, 32'd0);
        check("rst_fwd1_hit", 32'(fwd1_hit), 0);
        check("rst_fwd1_data", fwd1_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single A write, one-cycle latency
        drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 1, 0);
        state(1, 5'd5, 32'h1234);
        idle();
        state(0, 5'd0, 32'd0);

        // A and B together: A is older
        drive(1, 5'd3, 32'd10, 1, 5'd4, 32'd20, 1, 1);
        state(2, 5'd3, 32'd10);
        idle();
        state(1, 5'd4, 32'd20);
        idle();
        state(0, 5'd0, 32'd0);

        // Build to 3, B refused at count 3 when A stores; pointers wrap
        drive(1, 5'd8,  32'h80, 1, 5'd9,  32'h90, 1, 1);
        state(2, 5'd8, 32'h80);
        drive(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 1, 1);
        state(3, 5'd9, 32'h90);
        drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0, 1, 0);
        state(3, 5'd10, 32'hA0);
        drive(1, 5'd0,  32'hEE, 1, 5'd14, 32'hE0, 1, 1);
        state(3, 5'd11, 32'hB0);
        drive(0, 5'd0,  32'h0,  1, 5'd15, 32'hF0, 0, 1);
        state(3, 5'd12, 32'hC0);
        idle();
        state(2, 5'd14, 32'hE0);
        idle();
        state(1, 5'd15, 32'hF0);
        idle();
        state(0, 5'd0, 32'd0);

        // Forwarding returns the youngest pending value
        RN1 = 5'd7;
        RN2 = 5'd0;
        drive(1, 5'd7, 32'd1, 1, 5'd7, 32'd2, 1, 1);
        state(2, 5'd7, 32'd1);
        check("fwd1_hit_2pend", 32'(fwd1_hit), 1);
        check("fwd1_data_2pend", fwd1_data, 32'd2);
        check("fwd2_hit_rn0", 32'(fwd2_hit), 0);
        check("fwd2_data_rn0", fwd2_data, 0);
        idle();
        state(1, 5'd7, 32'd2);
        check("fwd1_hit_1pend", 32'(fwd1_hit), 1);
        check("fwd1_data_1pend", fwd1_data, 32'd2);
        idle();
        check("fwd1_hit_none", 32'(fwd1_hit), 0);
        check("fwd1_data_none", fwd1_data, 0);
        state(0, 5'd0, 32'd0);

        // Register 0 is acknowledged but dropped
        drive(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0, 1, 0);
        state(0, 5'd0, 32'd0);

        // Asynchronous reset with 3 pending entries
        drive(1, 5'd20, 32'd1, 1, 5'd21, 32'd2, 1, 1);
        state(2, 5'd20, 32'd1);
        drive(1, 5'd22, 32'd3, 1, 5'd23, 32'd4, 1, 1);
        state(3, 5'd21, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_RegWrite", 32'(RegWrite), 0);
        check("arst_count", 32'(count), 0);
        check("arst_empty", 32'(empty), 1);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            idle();
            state(0, 5'd0, 32'd0);
        end

        // 2-deep instance: full refuses even while popping
        a2_valid = 1; a2_wn = 5'd1; a2_wd = 32'h11;
        b2_valid = 1; b2_wn = 5'd2; b2_wd = 32'h22;
        #2;
        check("d2_a_ready_empty", 32'(a2_ready), 1);
        check("d2_b_ready_empty", 32'(b2_ready), 1);
        @(posedge clk); #1;
        a2_wn = 5'd3; a2_wd = 32'h33; b2_valid = 0;
        check("d2_count_full", 32'(count2), 2);
        check("d2_full", 32'(full2), 1);
        check("d2_WN_head", 32'(WN2), 1);
        check("d2_WD_head", WD2, 32'h11);
        check("d2_a_ready_full", 32'(a2_ready), 0);
        check("d2_b_ready_full", 32'(b2_ready), 0);
        @(posedge clk); #1;
        check("d2_count_after_pop", 32'(count2), 1);
        check("d2_full_after_pop", 32'(full2), 0);
        check("d2_WN_second", 32'(WN2), 2);
        check("d2_a_ready_retry", 32'(a2_ready), 1);
        @(posedge clk); #1;
        a2_valid = 0;
        check("d2_count_push_pop", 32'(count2), 1);
        check("d2_WN_third", 32'(WN2), 3);
        check("d2_WD_third", WD2, 32'h33);
        @(posedge clk); #1;
        check("d2_empty", 32'(empty2), 1);
        check("d2_RegWrite_idle", 32'(RegWrite2), 0);

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
